awb_stat_collect: RTL and testbench

Gray-world white-balance statistics front end for the ISP pixel pipe. It accumulates per-channel R/G/B sums over one active frame and derives a common reference `k_sum`. It then drives the 64-bit `channel_sum`/`k_sum`/`en_flag` interface of three successive-approximation gain dividers (one per channel), re-arming them each frame. It waits for all three `gain_ready` flags before accepting the next frame.

---
 rtl/awb_stat_collect.sv | 206 ++++++++++++++++++++
 tb/tb_awb_stat_collect.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/awb_stat_collect.sv
// awb_stat_collect: gray-world white-balance statistics front end.
// Accumulates per-channel R/G/B sums over one active frame, derives the shared
// reference k_sum (about the per-channel mean), then re-arms and drives three
// successive-approximation gain dividers until all report ready.
// Optional feature macro: AWB_CLIP_EN -- when defined, pixels with any
// component >= CLIP_TH are excluded from the sums and from the pixel count.
module awb_stat_collect #(
  parameter int PIX_W   = 8,
  parameter int CNT_W   = 24,
  parameter int CLIP_TH = 250,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             de,
  input  logic [PIX_W-1:0] pix_r,
  input  logic [PIX_W-1:0] pix_g,
  input  logic [PIX_W-1:0] pix_b,
  input  logic [2:0]       gain_ready,
  output logic [63:0]      sum_r,
  output logic [63:0]      sum_g,
  output logic [63:0]      sum_b,
  output logic [63:0]      k_sum,
  output logic             en_flag,
  output logic             div_rst_n,
  output logic [CNT_W-1:0] pix_cnt,
  output logic             stat_done,
  output logic             timeout_err
);

  localparam int SUM_W = PIX_W + CNT_W;
  // Sum of three channels (+2 bits) times 85 (+7 bits) fits in SUM_W+9; one spare bit.
  localparam int K_W   = SUM_W + 10;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  // Reject parameter sets the datapath cannot represent.
  if (SUM_W > 32 || CLIP_TH > (1 << PIX_W) || TIMEOUT < 1) begin : g_param_check
    $error("awb_stat_collect: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_LATCH,
    S_ARM,
    S_SEND
  } state_t;

  state_t                state_q, state_d;
  logic                  vsync_q;
  logic                  v_rise, v_fall;
  logic                  pix_ok;
  logic [2:0][PIX_W-1:0] pix_ch;
  logic [2:0][SUM_W-1:0] acc_q, acc_d, acc_sat;
  logic [2:0][SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CNT_W-1:0]      pcnt_q, pcnt_d;
  logic [K_W-1:0]        k_total, k_mul;
  logic [K_W-1:0]        k_q, k_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;
  logic                  en_q, en_d;
  logic                  drst_q, drst_d;
  logic                  done_q, done_d;
  logic                  terr_q, terr_d;

  assign v_rise = vsync & ~vsync_q;
  assign v_fall = ~vsync & vsync_q;

  assign pix_ch[0] = pix_r;
  assign pix_ch[1] = pix_g;
  assign pix_ch[2] = pix_b;

`ifdef AWB_CLIP_EN
  // Highlights would pull the gray-world estimate toward the clipped channel.
  assign pix_ok = de
                  && ({1'b0, pix_r} < (PIX_W+1)'(CLIP_TH))
                  && ({1'b0, pix_g} < (PIX_W+1)'(CLIP_TH))
                  && ({1'b0, pix_b} < (PIX_W+1)'(CLIP_TH));
`else
  assign pix_ok = de;
`endif

  // Saturating per-channel add: the carry out forces the accumulator to all-ones.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_acc
    logic [SUM_W:0] acc_wide;
    assign acc_wide    = {1'b0, acc_q[gi]} + (SUM_W+1)'(pix_ch[gi]);
    assign acc_sat[gi] = acc_wide[SUM_W] ? {SUM_W{1'b1}} : acc_wide[SUM_W-1:0];
  end

  // k_sum = (r+g+b)*85/256, i.e. roughly (r+g+b)/3.
  assign k_total = K_W'(acc_q[0]) + K_W'(acc_q[1]) + K_W'(acc_q[2]);
  assign k_mul   = k_total * K_W'(85);

  // Next-state and output logic for the frame / divider handshake FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    k_d     = k_q;
    pcnt_d  = pcnt_q;
    tcnt_d  = tcnt_q;
    en_d    = en_q;
    drst_d  = 1'b1;
    done_d  = 1'b0;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        if (v_rise) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (v_fall) begin
          state_d = S_LATCH;
        end else if (vsync && pix_ok) begin
          acc_d = acc_sat;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LATCH: begin
        if (cnt_q == '0) begin
          // Empty frame: nothing worth re-running the dividers for.
          state_d = S_IDLE;
        end else begin
          sum_d   = acc_q;
          k_d     = k_mul >> 8;
          pcnt_d  = cnt_q;
          drst_d  = 1'b0;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        // Operands are already stable, so the dividers start clean on release.
        en_d    = 1'b1;
        tcnt_d  = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (gain_ready == 3'b111) begin
          done_d  = 1'b1;
          en_d    = 1'b0;
          state_d = S_IDLE;
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          en_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  // State, accumulators and all registered outputs; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vsync_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      pcnt_q  <= '0;
      tcnt_q  <= '0;
      en_q    <= 1'b0;
      drst_q  <= 1'b1;
      done_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      pcnt_q  <= pcnt_d;
      tcnt_q  <= tcnt_d;
      en_q    <= en_d;
      drst_q  <= drst_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
    end
  end

  assign sum_r       = {{(64-SUM_W){1'b0}}, sum_q[0]};
  assign sum_g       = {{(64-SUM_W){1'b0}}, sum_q[1]};
  assign sum_b       = {{(64-SUM_W){1'b0}}, sum_q[2]};
  assign k_sum       = {{(64-K_W){1'b0}}, k_q};
  assign pix_cnt     = pcnt_q;
  assign en_flag     = en_q;
  assign div_rst_n   = drst_q;
  assign stat_done   = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_awb_stat_collect.sv
// tb_awb_stat_collect: directed test of awb_stat_collect (basic frame, empty
// frame, clipping, skipped frame, timeout, reset during SEND).
`timescale 1ns/1ps
module tb_awb_stat_collect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        de = 1'b0;
  logic [7:0]  pix_r = '0, pix_g = '0, pix_b = '0;
  logic [2:0]  gain_ready = '0;
  logic [63:0] sum_r, sum_g, sum_b, k_sum;
  logic        en_flag, div_rst_n, stat_done, timeout_err;
  logic [23:0] pix_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Event counters sampled on the falling edge.
  int           mon_rst_low = 0, mon_en_hi = 0, mon_done = 0, mon_unstable = 0;
  logic [255:0] hold_q = '0;
  logic         hold_vld = 1'b0;
  int           s_rst, s_en, s_done, s_unst;

  always #5 clk = ~clk;

  awb_stat_collect dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .de          (de),
    .pix_r       (pix_r),
    .pix_g       (pix_g),
    .pix_b       (pix_b),
    .gain_ready  (gain_ready),
    .sum_r       (sum_r),
    .sum_g       (sum_g),
    .sum_b       (sum_b),
    .k_sum       (k_sum),
    .en_flag     (en_flag),
    .div_rst_n   (div_rst_n),
    .pix_cnt     (pix_cnt),
    .stat_done   (stat_done),
    .timeout_err (timeout_err)
  );

  // Count re-arm pulses, enable cycles, done pulses and sum changes while busy.
  always @(negedge clk) begin
    if (!div_rst_n) mon_rst_low <= mon_rst_low + 1;
    if (en_flag)    mon_en_hi   <= mon_en_hi + 1;
    if (stat_done)  mon_done    <= mon_done + 1;
    if (en_flag || !div_rst_n) begin
      if (hold_vld && hold_q != {sum_r, sum_g, sum_b, k_sum}) mon_unstable <= mon_unstable + 1;
      hold_q   <= {sum_r, sum_g, sum_b, k_sum};
      hold_vld <= 1'b1;
    end else begin
      hold_vld <= 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    settle(1);
    s_rst  = mon_rst_low;
    s_en   = mon_en_hi;
    s_done = mon_done;
    s_unst = mon_unstable;
  endtask

  // One frame: a blank vsync cycle, rows of 'cols' pixels each followed by a
  // blank cycle, then vsync drops. clip4 forces r=255 on column 0.
  task automatic frame(input int rows, input int cols, input logic [7:0] r,
                       input logic [7:0] g, input logic [7:0] b, input bit clip4);
    vsync = 1'b1;
    de    = 1'b0;
    step();
    for (int y = 0; y < rows; y++) begin
      for (int x = 0; x < cols; x++) begin
        de    = 1'b1;
        pix_r = (clip4 && x == 0) ? 8'd255 : r;
        pix_g = g;
        pix_b = b;
        step();
      end
      de    = 1'b0;
      pix_r = '0;
      pix_g = '0;
      pix_b = '0;
      step();
    end
    vsync = 1'b0;
  endtask

  // Walk from the vsync fall (cycle N) to the first SEND cycle (N+3).
  task automatic expect_latch(input logic [63:0] er, input logic [63:0] eg,
                              input logic [63:0] eb, input logic [63:0] ek,
                              input logic [63:0] ec);
    @(negedge clk);                       // N
    @(negedge clk);                       // N+1: LATCH
    chk("rstn_in_latch", div_rst_n, 1);
    chk("en_in_latch", en_flag, 0);
    @(negedge clk);                       // N+2: ARM
    chk("sum_r", sum_r, er);
    chk("sum_g", sum_g, eg);
    chk("sum_b", sum_b, eb);
    chk("k_sum", k_sum, ek);
    chk("pix_cnt", pix_cnt, ec);
    chk("rstn_low_arm", div_rst_n, 0);
    chk("en_low_arm", en_flag, 0);
    @(negedge clk);                       // N+3: SEND
    chk("en_high_send", en_flag, 1);
    chk("rstn_high_send", div_rst_n, 1);
  endtask

  // Return ready 'd' cycles later and expect a single stat_done with en_flag low.
  task automatic finish_send(input int d);
    bit got;
    repeat (d) @(posedge clk);
    #1;
    gain_ready = 3'b111;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stat_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", got, 1);
    chk("en_low_at_done", en_flag, 0);
    step();
    gain_ready = 3'b000;
    @(negedge clk);
    chk("done_one_cycle", stat_done, 0);
  endtask

  initial begin
    // ---- Reset state ----
    repeat (3) @(negedge clk);
    chk("rst_sum_r", sum_r, 0);
    chk("rst_k_sum", k_sum, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    chk("rst_en", en_flag, 0);
    chk("rst_div_rst_n", div_rst_n, 1);
    chk("rst_done", stat_done, 0);
    chk("rst_terr", timeout_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // ---- Basic 4x4 frame: 1600/800/2400, k=(4800*85)>>8=1593 ----
    snap();
    frame(4, 4, 8'd100, 8'd50, 8'd150, 1'b0);
    expect_latch(1600, 800, 2400, 1593, 16);
    finish_send(10);
    settle(2);
    chk("basic_rst_pulses", mon_rst_low - s_rst, 1);
    chk("basic_en_cycles", mon_en_hi - s_en, 11);
    chk("basic_done_pulses", mon_done - s_done, 1);
    chk("basic_sum_stable", mon_unstable - s_unst, 0);
    chk("basic_terr", timeout_err, 0);

    // ---- Empty frame: nothing moves ----
    snap();
    vsync = 1'b1;
    de    = 1'b0;
    repeat (6) step();
    vsync = 1'b0;
    settle(40);
    chk("empty_rst_pulses", mon_rst_low - s_rst, 0);
    chk("empty_en_cycles", mon_en_hi - s_en, 0);
    chk("empty_done_pulses", mon_done - s_done, 0);
    chk("empty_sum_r_held", sum_r, 1600);
    chk("empty_k_held", k_sum, 1593);
    chk("empty_cnt_held", pix_cnt, 16);

    // ---- Clip frame: column 0 has r=255 ----
    frame(4, 4, 8'd100, 8'd50, 8'd150, 1'b1);
`ifdef AWB_CLIP_EN
    expect_latch(1200, 600, 1800, 1195, 12);
`else
    expect_latch(2220, 800, 2400, 1799, 16);
`endif
    finish_send(10);

    // ---- Skipped frame: a new frame arrives during SEND ----
    snap();
    frame(2, 2, 8'd10, 8'd20, 8'd30, 1'b0);
    expect_latch(40, 80, 120, 79, 4);
    frame(2, 2, 8'd200, 8'd200, 8'd200, 1'b0);
    chk("skip_en_still_high", en_flag, 1);
    finish_send(1);
    settle(20);
    chk("skip_rst_pulses", mon_rst_low - s_rst, 1);
    chk("skip_done_pulses", mon_done - s_done, 1);
    chk("skip_sum_r_kept", sum_r, 40);
    chk("skip_cnt_kept", pix_cnt, 4);
    frame(1, 3, 8'd7, 8'd8, 8'd9, 1'b0);
    expect_latch(21, 24, 27, 23, 3);
    finish_send(10);

    // ---- Timeout: ready stuck at 3'b011 ----
    snap();
    frame(1, 2, 8'd1, 8'd2, 8'd3, 1'b0);
    expect_latch(2, 4, 6, 3, 2);
    gain_ready = 3'b011;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!en_flag) break;
    end
    chk("to_en_dropped", en_flag, 0);
    chk("to_terr_set", timeout_err, 1);
    gain_ready = 3'b000;
    settle(3);
    chk("to_en_cycles", mon_en_hi - s_en, 32);
    chk("to_done_pulses", mon_done - s_done, 0);
    frame(4, 4, 8'd100, 8'd50, 8'd150, 1'b0);
    expect_latch(1600, 800, 2400, 1593, 16);
    finish_send(10);
    chk("to_terr_sticky", timeout_err, 1);

    // ---- Reset during SEND, then a clean frame ----
    frame(2, 2, 8'd10, 8'd20, 8'd30, 1'b0);
    expect_latch(40, 80, 120, 79, 4);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    chk("mrst_en", en_flag, 0);
    chk("mrst_div_rst_n", div_rst_n, 1);
    chk("mrst_sum_r", sum_r, 0);
    chk("mrst_k_sum", k_sum, 0);
    chk("mrst_pix_cnt", pix_cnt, 0);
    chk("mrst_terr", timeout_err, 0);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    frame(4, 4, 8'd100, 8'd50, 8'd150, 1'b0);
    expect_latch(1600, 800, 2400, 1593, 16);
    finish_send(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
